pipe_stage_buf: RTL

Parametrised, flow-controlled pipeline stage register that replaces the fixed MEM/WB latch and serves any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control field and a data payload with a valid/ready handshake, flush-to-bubble, and an optional two-entry skid mode. In skid mode, upstream stall (`in_ready`) is fully registered and throughput is one transfer per cycle. Control bits of any invalid entry read as zero, so a bubble never writes the register file or memory.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_entry_reg.sv | 33 +++
 rtl/pipe_stage_buf.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: MEM/WB control/payload layout and
// occupancy encodings for the flow-controlled stage buffer.
package pipe_pkg;

  localparam int unsigned WB_CTRL_W     = 2;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  localparam int unsigned MEM_WB_DATA_W = 69;

  localparam int unsigned READ_DATA_HI  = 68;
  localparam int unsigned READ_DATA_LO  = 37;
  localparam int unsigned ALU_RESULT_HI = 36;
  localparam int unsigned ALU_RESULT_LO = 5;
  localparam int unsigned WRITE_REG_HI  = 4;
  localparam int unsigned WRITE_REG_LO  = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single valid+ctrl+data holding register with load and clear.
// Clear drops valid and control but keeps the payload.
module pipe_entry_reg #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Flow-controlled pipeline stage register with flush-to-bubble and an
// optional two-entry skid buffer giving a registered upstream ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = WB_CTRL_W,
  parameter int unsigned DATA_W = MEM_WB_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              consume;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  if (SKID != 0) begin : g_skid
    occ_e              occ;
    occ_e              occ_next;
    logic              ready_q;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        occ     <= OCC_EMPTY;
        ready_q <= 1'b1;
      end else begin
        occ     <= occ_next;
        ready_q <= (occ_next != OCC_FULL);
      end
    end

    always_comb begin
      occ_next       = occ;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
        occ_next   = OCC_EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        unique case (occ)
          OCC_EMPTY: begin
            if (accept) begin
              occ_next  = OCC_ONE;
              main_load = 1'b1;
            end
          end
          OCC_ONE: begin
            if (accept && !consume) begin
              occ_next  = OCC_FULL;
              skid_load = 1'b1;
            end else if (accept && consume) begin
              main_load = 1'b1;
            end else if (consume) begin
              occ_next   = OCC_EMPTY;
              main_clear = 1'b1;
            end
          end
          OCC_FULL: begin
            if (consume && skid_valid) begin
              occ_next       = OCC_ONE;
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clear     = 1'b1;
            end
          end
          default: occ_next = OCC_EMPTY;
        endcase
      end
    end

    assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_ld_data = main_from_skid ? skid_data : in_data;
    assign in_ready     = ready_q;
    assign occupancy    = occ;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (main_load),
      .clear   (main_clear),
      .ld_ctrl (main_ld_ctrl),
      .ld_data (main_ld_data),
      .valid   (main_valid),
      .ctrl    (main_ctrl),
      .data    (main_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .clear   (skid_clear),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
    );
  end else begin : g_single
    logic main_load;
    logic main_clear;

    assign in_ready   = !main_valid || out_ready;
    // Flush wins; a consume with a same-cycle accept is a reload, not a clear.
    assign main_load  = accept && !flush;
    assign main_clear = flush || (consume && !accept);
    assign occupancy  = {1'b0, main_valid};

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (main_load),
      .clear   (main_clear),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (main_valid),
      .ctrl    (main_ctrl),
      .data    (main_data)
    );
  end

endmodule
